// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg
// Shared constants for the tick generator: the smallest divisor a channel
// accepts, the default parameter values, and a helper that sizes the
// channel-select field of the configuration port.
package tick_gen_pkg;

  // A divisor below two cannot produce a distinct tick and square phase.
  localparam int DIV_MIN          = 2;

  localparam int DEF_CHANNELS_VAL = 4;
  localparam int DEF_CNT_W_VAL    = 16;
  localparam int DEF_DIV_VAL      = 20;

  // A single-channel build still needs a one-bit select field.
  function automatic int ch_sel_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch
// One divider channel. It counts enabled clock edges modulo the active
// divisor and produces a one-cycle tick at each period boundary, plus a
// square wave whose period equals the divisor. A shadow divisor written
// through the configuration port waits as "pending" until the next period
// boundary, or until the channel is idle or resynchronised.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   en      in   run enable; low clears the channel
//   sync    in   restart strobe shared by all channels
//   wr      in   accepted configuration write aimed at this channel
//   wr_div  in   divisor carried by that write
//   tick    out  one-cycle pulse per period
//   sq      out  square wave, period = divisor
//   pend    out  a shadow divisor is waiting to be applied
module tick_gen_ch import tick_gen_pkg::*; #(
  parameter int CNT_W   = DEF_CNT_W_VAL,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] nxt;
  logic             boundary;
  logic             half;
  logic             apply;

  // The last count of a period, and the count on which sq rises so that it
  // is high for the final ceil(div/2) cycles of the period.
  assign boundary = (cnt == div - CNT_W'(1));
  assign half     = (cnt == (div >> 1) - CNT_W'(1));

  // Moments where a waiting divisor may be swapped in without cutting or
  // stretching a running period: the boundary itself, or any time the
  // counter is forced back to zero.
  assign apply = sync || !en || boundary;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      div  <= CNT_W'(DEF_DIV);
      nxt  <= CNT_W'(DEF_DIV);
      pend <= 1'b0;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      if (sync || !en) begin
        cnt  <= '0;
        tick <= 1'b0;
        sq   <= 1'b0;
      end else begin
        tick <= boundary;
        if (boundary) begin
          cnt <= '0;
          sq  <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (half) begin
            sq <= 1'b1;
          end
        end
      end

      if (apply && pend) begin
        div <= nxt;
      end

      // A write landing on an apply edge still reads the old shadow value
      // for div (non-blocking), so the new value simply stays pending.
      if (wr) begin
        nxt  <= wr_div;
        pend <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen
// Bank of independent divider channels sharing one configuration port and
// one resynchronisation strobe. Configuration writes are validated here;
// good writes reach the addressed channel and are acknowledged, bad ones
// are dropped and flagged.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   en        in   per-channel run enable
//   sync      in   restart all channels in phase
//   cfg_wr    in   configuration write strobe
//   cfg_ch    in   target channel of the write
//   cfg_div   in   new divisor
//   cfg_ack   out  one-cycle pulse, write accepted
//   cfg_err   out  one-cycle pulse, write rejected
//   cfg_pend  out  per-channel divisor update pending
//   tick      out  per-channel one-cycle pulse per period
//   sq        out  per-channel square wave
module tick_gen import tick_gen_pkg::*; #(
  parameter int CHANNELS = DEF_CHANNELS_VAL,
  parameter int CNT_W    = DEF_CNT_W_VAL,
  parameter int DEF_DIV  = DEF_DIV_VAL
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           en,
  input  logic                          sync,
  input  logic                          cfg_wr,
  input  logic [ch_sel_w(CHANNELS)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  output logic                          cfg_ack,
  output logic                          cfg_err,
  output logic [CHANNELS-1:0]           cfg_pend,
  output logic [CHANNELS-1:0]           tick,
  output logic [CHANNELS-1:0]           sq
);

  localparam int CH_W = ch_sel_w(CHANNELS);

  logic cfg_ok;

  // When CHANNELS is not a power of two the select field can name
  // channels that do not exist; those writes are rejected.
  assign cfg_ok = (cfg_div >= CNT_W'(DIV_MIN)) && (int'(cfg_ch) < CHANNELS);

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_wr && cfg_ok;
      cfg_err <= cfg_wr && !cfg_ok;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic ch_wr;

    assign ch_wr = cfg_wr && cfg_ok && (cfg_ch == CH_W'(i));

    tick_gen_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .sync   (sync),
      .wr     (ch_wr),
      .wr_div (cfg_div),
      .tick   (tick[i]),
      .sq     (sq[i]),
      .pend   (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen
// Scoreboarded bench for tick_gen. Three channels are used so that the
// two-bit channel select can address a channel that does not exist.
// The reference model tracks, per channel, how many enabled edges have
// elapsed in the current period and derives tick/sq from that position.
module tb_tick_gen;

  localparam int CHANNELS = 3;
  localparam int CNT_W    = 16;
  localparam int DEF_DIV  = 20;
  localparam int CH_W     = 2;

  typedef struct packed {
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] sq;
    logic [CHANNELS-1:0] pend;
    logic                ack;
    logic                err;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [CHANNELS-1:0] en;
  logic                sync;
  logic                cfg_wr;
  logic [CH_W-1:0]     cfg_ch;
  logic [CNT_W-1:0]    cfg_div;
  logic                cfg_ack;
  logic                cfg_err;
  logic [CHANNELS-1:0] cfg_pend;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] sq;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference state: position within the period, divisor, shadow, pending.
  int m_pos [CHANNELS];
  int m_div [CHANNELS];
  int m_nxt [CHANNELS];
  bit m_pend[CHANNELS];

  tick_gen #(
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W),
    .DEF_DIV  (DEF_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .cfg_pend (cfg_pend),
    .tick     (tick),
    .sq       (sq)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the coming edge
  // and queue what the outputs must look like after that edge.
  task automatic applyStimulus(input logic r, input logic [CHANNELS-1:0] e,
                               input logic s, input logic w,
                               input int ch, input int dv);
    exp_t x;
    bit   ok;
    @(negedge clk);
    reset   = r;
    en      = e;
    sync    = s;
    cfg_wr  = w;
    cfg_ch  = CH_W'(ch);
    cfg_div = CNT_W'(dv);
    ok = (dv >= 2) && (ch < CHANNELS);
    x = '0;
    x.ack = !r && w && ok;
    x.err = !r && w && !ok;
    for (int c = 0; c < CHANNELS; c++) begin
      bit at_apply;
      if (r) begin
        m_pos[c]  = 0;
        m_div[c]  = DEF_DIV;
        m_nxt[c]  = DEF_DIV;
        m_pend[c] = 0;
      end else begin
        at_apply = 1;
        if (s || !e[c]) begin
          m_pos[c] = 0;
        end else begin
          m_pos[c]++;
          x.tick[c] = (m_pos[c] == m_div[c]);
          x.sq[c]   = (m_pos[c] >= m_div[c] / 2) && (m_pos[c] < m_div[c]);
          if (m_pos[c] == m_div[c]) m_pos[c] = 0;
          else at_apply = 0;
        end
        if (at_apply && m_pend[c]) begin
          m_div[c]  = m_nxt[c];
          m_pend[c] = 0;
        end
        if (w && ok && ch == c) begin
          m_nxt[c]  = dv;
          m_pend[c] = 1;
        end
      end
      x.pend[c] = m_pend[c];
    end
    exp_q.push_back(x);
  endtask

  task automatic checkOutput(input exp_t x);
    checks += 5;
    if (tick !== x.tick) begin
      fails++;
      $display("[TB] FAIL tick @%0t got %b want %b", $time, tick, x.tick);
    end
    if (sq !== x.sq) begin
      fails++;
      $display("[TB] FAIL sq @%0t got %b want %b", $time, sq, x.sq);
    end
    if (cfg_pend !== x.pend) begin
      fails++;
      $display("[TB] FAIL cfg_pend @%0t got %b want %b", $time, cfg_pend, x.pend);
    end
    if (cfg_ack !== x.ack) begin
      fails++;
      $display("[TB] FAIL cfg_ack @%0t got %b want %b", $time, cfg_ack, x.ack);
    end
    if (cfg_err !== x.err) begin
      fails++;
      $display("[TB] FAIL cfg_err @%0t got %b want %b", $time, cfg_err, x.err);
    end
  endtask

  // Monitor: outputs are presented every cycle, so every edge with a queued
  // expectation is compared shortly after the edge settles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  task automatic idle(input logic [CHANNELS-1:0] e, input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, e, 0, 0, 0, 0);
  endtask

  initial begin
    logic [CHANNELS-1:0] e;
    reset = 1; en = '0; sync = 0; cfg_wr = 0; cfg_ch = '0; cfg_div = '0;

    $display("[TB] reset and default divisor");
    for (int i = 0; i < 3; i++) applyStimulus(1, '0, 0, 0, 0, 0);
    idle(3'b001, 65);

    $display("[TB] small divisors on channel 1");
    applyStimulus(0, 3'b001, 0, 1, 1, 3);
    idle(3'b011, 12);
    applyStimulus(0, 3'b011, 0, 1, 1, 2);
    idle(3'b011, 8);
    idle(3'b010, 1);
    idle(3'b011, 8);

    $display("[TB] mid-period divisor change on channel 0");
    applyStimulus(0, 3'b000, 0, 0, 0, 0);
    idle(3'b001, 5);
    applyStimulus(0, 3'b001, 0, 1, 0, 8);
    idle(3'b001, 30);

    $display("[TB] rejected writes");
    applyStimulus(0, 3'b001, 0, 1, 0, 1);
    applyStimulus(0, 3'b001, 0, 1, 3, 5);
    applyStimulus(0, 3'b001, 0, 1, 2, 0);
    idle(3'b001, 4);

    $display("[TB] sync of channels at divisors 6 and 9");
    applyStimulus(0, 3'b000, 0, 1, 0, 6);
    applyStimulus(0, 3'b000, 0, 1, 2, 9);
    idle(3'b000, 1);
    idle(3'b001, 4);
    idle(3'b101, 7);
    applyStimulus(0, 3'b101, 1, 1, 0, 7);
    idle(3'b101, 20);

    $display("[TB] reset while a write is pending");
    applyStimulus(0, 3'b101, 0, 1, 2, 4);
    idle(3'b101, 2);
    applyStimulus(1, 3'b101, 1, 1, 0, 5);
    idle(3'b101, 25);

    $display("[TB] randomized traffic");
    e = 3'b111;
    for (int i = 0; i < 1500; i++) begin
      logic r, s, w;
      if ($urandom_range(0, 39) == 0) e[$urandom_range(0, CHANNELS - 1)] ^= 1'b1;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 7) == 0);
      applyStimulus(r, e, s, w, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
